// File: rtl/fwd_hazard_unit.sv
// ============================================================================
// Module   : fwd_hazard_unit
// Brief    : Decode-stage operand bypass, load-use / mul-div scoreboard stall
//            and stall watchdog. Define FWD_STATS_EN for performance counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_hazard_unit #(
    parameter int NUM_RD   = 2,
    parameter int NUM_STG  = 3,
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int WDOG_MAX = 255
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*REG_AW-1:0]   rd_addr,
    input  logic [NUM_RD*DATA_W-1:0]   rf_data,
    input  logic [NUM_STG-1:0]         stg_wen,
    input  logic [NUM_STG-1:0]         stg_rdy,
    input  logic [NUM_STG*REG_AW-1:0]  stg_waddr,
    input  logic [NUM_STG*DATA_W-1:0]  stg_wdata,
    input  logic                       lo_issue,
    input  logic [REG_AW-1:0]          lo_waddr,
    input  logic                       lo_done,
    input  logic [REG_AW-1:0]          lo_done_addr,
    input  logic                       sb_clear,
    output logic [NUM_RD*DATA_W-1:0]   opnd,
`ifdef FWD_STATS_EN
    output logic [31:0]                stat_stall_cyc,
    output logic [31:0]                stat_fwd_hits,
`endif
    output logic                       stall,
    output logic                       sb_err,
    output logic                       hang
);

    localparam int          c_SB_W     = 2**REG_AW;
    localparam logic [15:0] c_WDOG_MAX = 16'(WDOG_MAX);

    logic [c_SB_W-1:0] sb_q, sb_d;
    logic              sb_err_q, sb_err_d;
    logic [15:0]       wdog_q, wdog_d;
    logic              hang_q, hang_d;
    logic [NUM_RD-1:0] w_req;
`ifdef FWD_STATS_EN
    logic [NUM_RD-1:0] w_fwd;
    logic [31:0]       stall_cyc_q, stall_cyc_d;
    logic [31:0]       fwd_hits_q, fwd_hits_d;
    logic [31:0]       w_fwd_cnt;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_port
            logic [REG_AW-1:0] w_addr;
            logic              w_hit;
            logic              w_rdy;
            logic [DATA_W-1:0] w_data;

            assign w_addr = rd_addr[gi*REG_AW +: REG_AW];

            // Descending scan so the youngest matching stage overrides older ones.
            always_comb begin
                w_hit  = 1'b0;
                w_rdy  = 1'b0;
                w_data = '0;
                for (int s = NUM_STG-1; s >= 0; s--) begin
                    if (stg_wen[s] && (stg_waddr[s*REG_AW +: REG_AW] == w_addr)) begin
                        w_hit  = 1'b1;
                        w_rdy  = stg_rdy[s];
                        w_data = stg_wdata[s*DATA_W +: DATA_W];
                    end
                end
            end

            always_comb begin
                opnd[gi*DATA_W +: DATA_W] = rf_data[gi*DATA_W +: DATA_W];
                w_req[gi]                 = 1'b0;
                if (w_addr == '0) begin
                    opnd[gi*DATA_W +: DATA_W] = '0;
                end else if (w_hit && w_rdy) begin
                    opnd[gi*DATA_W +: DATA_W] = w_data;
                end else if (w_hit) begin
                    w_req[gi] = rd_en[gi];
                end else begin
                    w_req[gi] = rd_en[gi] & sb_q[w_addr];
                end
            end

`ifdef FWD_STATS_EN
            assign w_fwd[gi] = rd_en[gi] && (w_addr != '0) && w_hit && w_rdy;
`endif
        end
    endgenerate

    assign stall = |w_req;

    // Issue is applied after clear/done so a same-cycle set always wins.
    always_comb begin
        sb_d     = sb_q;
        sb_err_d = sb_err_q;
        if (sb_clear) begin
            sb_d = '0;
        end else if (lo_done) begin
            sb_d[lo_done_addr] = 1'b0;
        end
        if (lo_issue && (lo_waddr != '0)) begin
            sb_d[lo_waddr] = 1'b1;
            if (sb_q[lo_waddr]) begin
                sb_err_d = 1'b1;
            end
        end
    end

    always_comb begin
        wdog_d = '0;
        if (stall) begin
            wdog_d = (wdog_q == c_WDOG_MAX) ? wdog_q : wdog_q + 16'd1;
        end
        hang_d = hang_q | (wdog_d == c_WDOG_MAX);
    end

`ifdef FWD_STATS_EN
    always_comb begin
        w_fwd_cnt = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            w_fwd_cnt = w_fwd_cnt + 32'(w_fwd[i]);
        end
        stall_cyc_d = stall_cyc_q + 32'(stall);
        fwd_hits_d  = fwd_hits_q + w_fwd_cnt;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            stall_cyc_q <= '0;
            fwd_hits_q  <= '0;
        end else begin
            stall_cyc_q <= stall_cyc_d;
            fwd_hits_q  <= fwd_hits_d;
        end
    end

    assign stat_stall_cyc = stall_cyc_q;
    assign stat_fwd_hits  = fwd_hits_q;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sb_q     <= '0;
            sb_err_q <= 1'b0;
            wdog_q   <= '0;
            hang_q   <= 1'b0;
        end else begin
            sb_q     <= sb_d;
            sb_err_q <= sb_err_d;
            wdog_q   <= wdog_d;
            hang_q   <= hang_d;
        end
    end

    assign sb_err = sb_err_q;
    assign hang   = hang_q;

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
// ============================================================================
// Module   : tb_fwd_hazard_unit
// Brief    : Directed self-checking bench for fwd_hazard_unit (WDOG_MAX = 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fwd_hazard_unit;

    localparam int NUM_RD   = 2;
    localparam int NUM_STG  = 3;
    localparam int DATA_W   = 32;
    localparam int REG_AW   = 5;

    logic                      clk = 1'b0;
    logic                      resetn;
    logic [NUM_RD-1:0]         rd_en;
    logic [NUM_RD*REG_AW-1:0]  rd_addr;
    logic [NUM_RD*DATA_W-1:0]  rf_data;
    logic [NUM_STG-1:0]        stg_wen;
    logic [NUM_STG-1:0]        stg_rdy;
    logic [NUM_STG*REG_AW-1:0] stg_waddr;
    logic [NUM_STG*DATA_W-1:0] stg_wdata;
    logic                      lo_issue;
    logic [REG_AW-1:0]         lo_waddr;
    logic                      lo_done;
    logic [REG_AW-1:0]         lo_done_addr;
    logic                      sb_clear;
    logic [NUM_RD*DATA_W-1:0]  opnd;
    logic                      stall;
    logic                      sb_err;
    logic                      hang;
`ifdef FWD_STATS_EN
    logic [31:0]               stat_stall_cyc;
    logic [31:0]               stat_fwd_hits;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(
        .NUM_RD   (NUM_RD),
        .NUM_STG  (NUM_STG),
        .DATA_W   (DATA_W),
        .REG_AW   (REG_AW),
        .WDOG_MAX (4)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rf_data      (rf_data),
        .stg_wen      (stg_wen),
        .stg_rdy      (stg_rdy),
        .stg_waddr    (stg_waddr),
        .stg_wdata    (stg_wdata),
        .lo_issue     (lo_issue),
        .lo_waddr     (lo_waddr),
        .lo_done      (lo_done),
        .lo_done_addr (lo_done_addr),
        .sb_clear     (sb_clear),
        .opnd         (opnd),
`ifdef FWD_STATS_EN
        .stat_stall_cyc (stat_stall_cyc),
        .stat_fwd_hits  (stat_fwd_hits),
`endif
        .stall        (stall),
        .sb_err       (sb_err),
        .hang         (hang)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge; inputs change and outputs settle 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_stg(input int s, input logic wen, input logic rdy,
                           input logic [REG_AW-1:0] a, input logic [DATA_W-1:0] d);
        stg_wen[s]                    = wen;
        stg_rdy[s]                    = rdy;
        stg_waddr[s*REG_AW +: REG_AW] = a;
        stg_wdata[s*DATA_W +: DATA_W] = d;
    endtask

    task automatic clr_stg();
        stg_wen   = '0;
        stg_rdy   = '0;
        stg_waddr = '0;
        stg_wdata = '0;
    endtask

    task automatic issue(input logic [REG_AW-1:0] a);
        lo_issue = 1'b1;
        lo_waddr = a;
        step();
        lo_issue = 1'b0;
    endtask

    initial begin
        resetn       = 1'b0;
        rd_en        = '0;
        rd_addr      = '0;
        rf_data      = {32'h2222_2222, 32'h1111_1111};
        lo_issue     = 1'b0;
        lo_waddr     = '0;
        lo_done      = 1'b0;
        lo_done_addr = '0;
        sb_clear     = 1'b0;
        clr_stg();
        step();
        step();

        // Reset state
        rd_addr[4:0] = 5'd2;
        #1;
        check("rst_sb_err", sb_err, 0);
        check("rst_hang",   hang,   0);
        check("rst_stall",  stall,  0);
        check("rst_opnd0",  opnd[31:0],  32'h1111_1111);
        check("rst_opnd1_r0", opnd[63:32], 32'h0);
        resetn = 1'b1;

        // Bypass priority
        rd_en        = 2'b01;
        rd_addr[4:0] = 5'd5;
        set_stg(0, 1'b1, 1'b1, 5'd5, 32'hA);
        set_stg(1, 1'b1, 1'b1, 5'd5, 32'hB);
        set_stg(2, 1'b1, 1'b1, 5'd5, 32'hC);
        #1;
        check("byp_ex",       opnd[31:0], 32'hA);
        check("byp_ex_stall", stall,      0);
        stg_wen[0] = 1'b0;
        #1;
        check("byp_mem", opnd[31:0], 32'hB);
        stg_wen[1] = 1'b0;
        #1;
        check("byp_wb",  opnd[31:0], 32'hC);
        clr_stg();

        // Load-use
        rd_en         = 2'b10;
        rd_addr[9:5]  = 5'd7;
        set_stg(0, 1'b1, 1'b0, 5'd7, 32'h0);
        #1;
        check("lu_stall", stall, 1);
        step();
        clr_stg();
        set_stg(1, 1'b1, 1'b1, 5'd7, 32'h1234);
        #1;
        check("lu_nostall", stall, 0);
        check("lu_opnd1",   opnd[63:32], 32'h1234);
        clr_stg();

        // Zero register
        rd_en        = 2'b01;
        rd_addr      = '0;
        set_stg(0, 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF);
        #1;
        check("r0_opnd",  opnd[31:0], 32'h0);
        check("r0_stall", stall, 0);
        stg_rdy[0] = 1'b0;
        #1;
        check("r0_notrdy_stall", stall, 0);
        clr_stg();
        rd_en = '0;

        // Scoreboard
        issue(5'd9);
        rd_en        = 2'b01;
        rd_addr[4:0] = 5'd9;
        #1;
        check("sb_stall",   stall, 1);
        check("sb_opnd_rf", opnd[31:0], 32'h1111_1111);
        lo_done      = 1'b1;
        lo_done_addr = 5'd9;
        #1;
        check("sb_done_same_cycle", stall, 1);
        step();
        lo_done = 1'b0;
        #1;
        check("sb_done_after", stall, 0);
        rd_en        = '0;
        lo_done      = 1'b1;
        issue(5'd9);
        lo_done      = 1'b0;
        rd_en        = 2'b01;
        #1;
        check("sb_set_wins", stall, 1);
        check("sb_err_clear", sb_err, 0);
        rd_en = '0;
        issue(5'd9);
        check("sb_err_set", sb_err, 1);
        rd_en = 2'b01;
        #1;
        check("sb_err_bit_kept", stall, 1);
        rd_en = '0;

        // Flush
        issue(5'd3);
        issue(5'd4);
        sb_clear = 1'b1;
        issue(5'd6);
        sb_clear = 1'b0;
        rd_en        = 2'b11;
        rd_addr[4:0] = 5'd3;
        rd_addr[9:5] = 5'd4;
        #1;
        check("flush_r3_r4", stall, 0);
        rd_addr[4:0] = 5'd6;
        #1;
        check("flush_r6", stall, 1);
        rd_en = '0;

        // Reset mid-operation discards pending bits and sb_err
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        check("rst2_sb_err", sb_err, 0);
        rd_en        = 2'b01;
        rd_addr[4:0] = 5'd6;
        #1;
        check("rst2_sb_cleared", stall, 0);

        // Watchdog
        rd_addr[4:0] = 5'd5;
        set_stg(0, 1'b1, 1'b0, 5'd5, 32'h0);
        step();
        step();
        step();
        check("wd_3cyc", hang, 0);
        rd_en = '0;
        step();
        rd_en = 2'b01;
        step();
        step();
        step();
        check("wd_broken_3cyc", hang, 0);
        step();
        check("wd_4cyc", hang, 1);
        rd_en = '0;
        step();
        step();
        check("wd_sticky", hang, 1);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        check("wd_reset", hang, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the decode stage. Generalises the single-operand, two-stage bypass to NUM_RD read ports and NUM_STG producer stages.
- Adds load-use stall detection and a scoreboard of in-flight multi-cycle writes from the mul/div unit.
- Adds a stall watchdog that flags a pipeline hang.
- Sits between the register file read and the decode/issue latch; its stall output gates the PC and decode registers.

Parameters:
- NUM_RD, 2, number of source-operand read ports.
- NUM_STG, 3, number of producer stages; index 0 is youngest (EX), then MEM, then WB.
- DATA_W, 32, data width.
- REG_AW, 5, register address width; the scoreboard has 2**REG_AW bits.
- WDOG_MAX, 255, consecutive stall cycles before the hang flag is set; range 1..65535.

Ports:
- clk  input  1  clock
- resetn  input  1  synchronous active-low reset
- rd_en  input  NUM_RD  port i reads a register this cycle
- rd_addr  input  NUM_RD*REG_AW  source register for port i (slice i)
- rf_data  input  NUM_RD*DATA_W  register-file value for port i
- stg_wen  input  NUM_STG  stage s will write a register
- stg_rdy  input  NUM_STG  stage s result is available (0 for a load still in EX)
- stg_waddr  input  NUM_STG*REG_AW  stage s destination register
- stg_wdata  input  NUM_STG*DATA_W  stage s result
- lo_issue  input  1  multi-cycle op issued this cycle
- lo_waddr  input  REG_AW  destination of the issued op
- lo_done  input  1  multi-cycle op completing this cycle
- lo_done_addr  input  REG_AW  destination of the completing op
- sb_clear  input  1  flush: drop all pending scoreboard entries
- opnd  output  NUM_RD*DATA_W  forwarded operand for port i
- stall  output  1  hold fetch/decode this cycle
- sb_err  output  1  sticky: issue to an already-pending register
- hang  output  1  sticky: stall held for WDOG_MAX consecutive cycles

Behaviour:
- Clock and reset: single clock clk; synchronous, active-low reset resetn.
- Reset state: scoreboard all 0; stall counter 0; sb_err = 0; hang = 0.
  - Combinational outputs reset to the no-hazard values: opnd = rf_data, or 0 for r0.
  - stall = 0 when rd_en = 0.
- Operand select, per port i, combinational with zero latency:
  - If rd_addr == 0: opnd = 0 and no stall contribution.
  - Otherwise, the lowest stage index s with stg_wen[s] && stg_waddr[s] == rd_addr is the match; younger stages win.
  - If the matching stage has stg_rdy[s] = 1: opnd = stg_wdata[s], no stall.
  - If the matching stage has stg_rdy[s] = 0: stall request; opnd = rf_data (don't-care to the consumer).
  - If no stage matches and the scoreboard bit for rd_addr is set: stall request; opnd = rf_data.
  - If no stage matches and the bit is clear: opnd = rf_data.
  - If rd_en[i] = 0: port i produces no stall request; opnd is still computed.
- stall is the OR of all port requests. It does not depend on the scoreboard updates made at the same clock edge.
- Scoreboard, updated at the clock edge:
  - lo_done clears bit lo_done_addr.
  - lo_issue sets bit lo_waddr; address 0 is ignored.
  - If both target the same address in one cycle, set wins.
  - lo_issue to an already-set bit sets sb_err; the bit stays set.
  - sb_clear clears all bits. It has priority over a same-cycle lo_done, but a same-cycle lo_issue still sets its bit.
- Watchdog:
  - The counter increments each cycle stall = 1 and saturates at WDOG_MAX.
  - It resets to 0 on any cycle with stall = 0.
  - When the counter reaches WDOG_MAX, hang is set.
  - hang and sb_err clear only on reset.
- Reset mid-operation: pending scoreboard bits are discarded; the owner must also reset the mul/div unit.

Optional Feature:
- Macro: FWD_STATS_EN.
- When defined:
  - Adds outputs stat_stall_cyc (32 bits) and stat_fwd_hits (32 bits), both reset to 0.
  - stat_stall_cyc increments each cycle stall = 1.
  - stat_fwd_hits increments each cycle by the number of ports that were forwarded from a stage without a stall.
  - Both counters wrap modulo 2^32.
- When undefined: the outputs and counters do not exist; all other behaviour is unchanged.

Test Plan:
- Bypass priority: port0 reads r5; stg_wen = 3'b111, all waddr = 5; data EX = 0xA, MEM = 0xB, WB = 0xC; all rdy = 1 -> opnd0 = 0xA, stall = 0. Drop the EX wen -> opnd0 = 0xB.
- Load-use: port1 reads r7; EX writes r7 with rdy = 0 -> stall = 1. Next cycle the load sits in MEM with rdy = 1 and data 0x1234 -> stall = 0, opnd1 = 0x1234.
- Zero register: rd_addr = 0; EX writes r0 with data 0xFFFF_FFFF -> opnd = 0, stall = 0.
- Scoreboard: lo_issue r9; next cycle port0 reads r9 -> stall = 1.
  - lo_done r9 -> stall drops the following cycle.
  - Same-cycle lo_issue and lo_done on r9 -> bit stays set.
  - A second issue to r9 while pending -> sb_err = 1.
- Flush: set r3 and r4 pending; pulse sb_clear together with lo_issue r6 -> only r6 is pending afterwards.
- Watchdog: WDOG_MAX = 4; hold a stall -> hang rises after exactly 4 stall cycles and stays high after the stall clears. A broken 3-cycle stall does not set hang; resetn = 0 clears it.
